// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller and its arbiter.
package irq_pkg;

   localparam logic [1:0] EncIdle    = 2'd0;
   localparam logic [1:0] EncReq     = 2'd1;
   localparam logic [1:0] EncService = 2'd2;

   typedef enum logic [1:0] {
      StIdle    = EncIdle,
      StReq     = EncReq,
      StService = EncService
   } irq_state_e;

   // Constant-foldable ceil(log2(n)), never less than 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Interrupt request/handshake bundle between interrupt sources, controller and CPU side.
interface irq_ctrl_if
   import irq_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned VEC_W = clog2(NCH)
);

   logic [NCH-1:0]   irq_in;
   logic [NCH-1:0]   irq_mask;
   logic             irq_ack;
   logic             irq_done;
   logic             irq_req;
   logic [VEC_W-1:0] irq_vec;
   logic [NCH-1:0]   pending;
   logic             busy;
   logic             overrun;

   modport master (
      output irq_in, irq_mask, irq_ack, irq_done,
      input  irq_req, irq_vec, pending, busy, overrun
   );

   modport slave (
      input  irq_in, irq_mask, irq_ack, irq_done,
      output irq_req, irq_vec, pending, busy, overrun
   );

endinterface

// File: rtl/irq_arbiter.sv
// Combinational arbiter: fixed lowest-index priority or round-robin search from rr_ptr.
module irq_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] rr_ptr,
   input  logic             rr_mode,
   output logic [IDX_W-1:0] winner,
   output logic             any_valid
);

   int unsigned start;
   int unsigned idx;
   logic        found;

   always_comb begin
      winner    = '0;
      any_valid = |req;
      found     = 1'b0;
      idx       = 0;
      start     = rr_mode ? int'(rr_ptr) : 0;
      for (int i = 0; i < int'(N); i++) begin
         idx = start + i;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            winner = IDX_W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-detecting, maskable, prioritised interrupt controller with req/ack/done handshake.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned NCH     = 4,
   parameter bit          RR_MODE = 1'b0,
   localparam int unsigned VEC_W  = clog2(NCH)
) (
   input logic       clk,
   input logic       rst,
   irq_ctrl_if.slave bus
);

   irq_state_e       state_q;
   logic [NCH-1:0]   irq_prev_q;
   logic [NCH-1:0]   pending_q;
   logic [VEC_W-1:0] vec_q;
   logic [VEC_W-1:0] rr_ptr_q;
   logic             req_q;
   logic             busy_q;
   logic             overrun_q;

   logic [NCH-1:0]   edge_det;
   logic [NCH-1:0]   clear;
   logic [NCH-1:0]   masked;
   logic [NCH-1:0]   pending_d;
   logic [VEC_W-1:0] winner;
   logic             any_valid;
   logic [VEC_W-1:0] rr_next;

   assign edge_det = bus.irq_in & ~irq_prev_q;
   assign masked   = pending_q & bus.irq_mask;

   always_comb begin
      clear = '0;
      if (state_q == StReq && bus.irq_ack) clear[vec_q] = 1'b1;
   end

   // A fresh edge in the ack cycle survives the clear.
   assign pending_d = (pending_q & ~clear) | edge_det;
   assign rr_next   = (vec_q == VEC_W'(NCH - 1)) ? '0 : vec_q + VEC_W'(1);

   irq_arbiter #(
      .N     (NCH),
      .IDX_W (VEC_W)
   ) u_arbiter (
      .req       (masked),
      .rr_ptr    (rr_ptr_q),
      .rr_mode   (RR_MODE),
      .winner    (winner),
      .any_valid (any_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         irq_prev_q <= '0;
         pending_q  <= '0;
         vec_q      <= '0;
         rr_ptr_q   <= '0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         irq_prev_q <= bus.irq_in;
         pending_q  <= pending_d;
         overrun_q  <= |(edge_det & pending_q & ~clear);
         unique case (state_q)
            StIdle: begin
               if (any_valid) begin
                  vec_q   <= winner;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= StReq;
               end
            end
            StReq: begin
               if (bus.irq_ack) begin
                  req_q   <= 1'b0;
                  state_q <= StService;
               end
            end
            StService: begin
               if (bus.irq_done) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
                  if (RR_MODE) rr_ptr_q <= rr_next;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.irq_req = req_q;
   assign bus.irq_vec = vec_q;
   assign bus.pending = pending_q;
   assign bus.busy    = busy_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: fixed-priority and round-robin instances, NCH = 4.
module tb_irq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   irq_ctrl_if #(.NCH(4)) fi ();
   irq_ctrl_if #(.NCH(4)) ri ();

   irq_ctrl #(.NCH(4), .RR_MODE(1'b0)) u_fix (.clk(clk), .rst(rst), .bus(fi));
   irq_ctrl #(.NCH(4), .RR_MODE(1'b1)) u_rr  (.clk(clk), .rst(rst), .bus(ri));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fi.irq_in = '0; fi.irq_mask = '0; fi.irq_ack = 1'b0; fi.irq_done = 1'b0;
      ri.irq_in = '0; ri.irq_mask = '0; ri.irq_ack = 1'b0; ri.irq_done = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({fi.irq_req, fi.busy, fi.overrun, fi.irq_vec, fi.pending} !== 9'b0) begin
         fails++;
         $display("FAIL reset_state: got %b expected 0",
                  {fi.irq_req, fi.busy, fi.overrun, fi.irq_vec, fi.pending});
      end
      fi.irq_mask = 4'hF;
      fi.irq_in   = 4'b0110;
      step();
      step();
      tests++;
      if ({fi.irq_req, fi.pending} !== 5'b1_0110) begin
         fails++;
         $display("FAIL reset_setup_req: got %b expected 10110", {fi.irq_req, fi.pending});
      end
      rst       = 1'b1;
      fi.irq_in = '0;
      #1;
      tests++;
      if ({fi.irq_req, fi.busy, fi.pending} !== 6'b0) begin
         fails++;
         $display("FAIL reset_async: got %b expected 0", {fi.irq_req, fi.busy, fi.pending});
      end
      step();
      rst = 1'b0;
      step();
      step();
      step();
      tests++;
      if ({fi.irq_req, fi.busy, fi.pending} !== 6'b0) begin
         fails++;
         $display("FAIL reset_after_release: got %b expected 0",
                  {fi.irq_req, fi.busy, fi.pending});
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      fi.irq_in   = 4'b1010;
      fi.irq_mask = 4'hF;
      step();
      tests++;
      if ({fi.irq_req, fi.pending} !== 5'b0_1010) begin
         fails++;
         $display("FAIL fixed_latch: got %b expected 01010", {fi.irq_req, fi.pending});
      end
      step();
      tests++;
      if ({fi.irq_req, fi.irq_vec, fi.busy} !== 4'b1_01_1) begin
         fails++;
         $display("FAIL fixed_first_req: got %b expected 1011",
                  {fi.irq_req, fi.irq_vec, fi.busy});
      end
      fi.irq_ack = 1'b1;
      step();
      fi.irq_ack = 1'b0;
      tests++;
      if ({fi.irq_req, fi.busy, fi.pending} !== 6'b0_1_1000) begin
         fails++;
         $display("FAIL fixed_ack: got %b expected 011000", {fi.irq_req, fi.busy, fi.pending});
      end
      fi.irq_done = 1'b1;
      step();
      fi.irq_done = 1'b0;
      tests++;
      if ({fi.irq_req, fi.busy} !== 2'b00) begin
         fails++;
         $display("FAIL fixed_idle_gap: got %b expected 00", {fi.irq_req, fi.busy});
      end
      step();
      tests++;
      if ({fi.irq_req, fi.irq_vec} !== 3'b1_11) begin
         fails++;
         $display("FAIL fixed_second_req: got %b expected 111", {fi.irq_req, fi.irq_vec});
      end
      fi.irq_ack = 1'b1;
      step();
      fi.irq_ack  = 1'b0;
      fi.irq_done = 1'b1;
      step();
      fi.irq_done = 1'b0;
      fi.irq_in   = '0;
      step();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_vec [5];
      exp_vec = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      ri.irq_mask = 4'hF;
      for (int k = 0; k < 5; k++) begin
         ri.irq_in = 4'hF;
         step();
         ri.irq_in = '0;
         for (int n = 0; n < 8; n++) begin
            if (ri.irq_req) break;
            step();
         end
         tests++;
         if ({ri.irq_req, ri.irq_vec} !== {1'b1, exp_vec[k]}) begin
            fails++;
            $display("FAIL rr_grant_%0d: got req=%b vec=%0d expected req=1 vec=%0d",
                     k, ri.irq_req, ri.irq_vec, exp_vec[k]);
         end
         ri.irq_ack = 1'b1;
         step();
         ri.irq_ack  = 1'b0;
         ri.irq_done = 1'b1;
         step();
         ri.irq_done = 1'b0;
      end
   endtask

   task automatic test_masking();
      do_reset();
      fi.irq_mask = 4'b1011;
      fi.irq_in   = 4'b0100;
      step();
      step();
      tests++;
      if ({fi.irq_req, fi.pending} !== 5'b0_0100) begin
         fails++;
         $display("FAIL mask_blocked: got %b expected 00100", {fi.irq_req, fi.pending});
      end
      fi.irq_mask = 4'hF;
      step();
      tests++;
      if ({fi.irq_req, fi.irq_vec} !== 3'b1_10) begin
         fails++;
         $display("FAIL mask_enabled: got %b expected 110", {fi.irq_req, fi.irq_vec});
      end
      fi.irq_ack = 1'b1;
      step();
      fi.irq_ack  = 1'b0;
      fi.irq_done = 1'b1;
      step();
      fi.irq_done = 1'b0;
      fi.irq_in   = '0;
      step();
   endtask

   task automatic test_overrun();
      do_reset();
      fi.irq_mask = 4'hF;
      fi.irq_in   = 4'b0001;
      step();
      fi.irq_in = '0;
      step();
      fi.irq_in = 4'b0001;
      step();
      tests++;
      if ({fi.overrun, fi.pending[0]} !== 2'b11) begin
         fails++;
         $display("FAIL overrun_pulse: got %b expected 11", {fi.overrun, fi.pending[0]});
      end
      fi.irq_in = '0;
      step();
      tests++;
      if (fi.overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_single_cycle: got %b expected 0", fi.overrun);
      end
      fi.irq_ack = 1'b1;
      fi.irq_in  = 4'b0001;
      step();
      fi.irq_ack = 1'b0;
      tests++;
      if ({fi.pending[0], fi.overrun, fi.irq_req} !== 3'b100) begin
         fails++;
         $display("FAIL set_wins: got %b expected 100", {fi.pending[0], fi.overrun, fi.irq_req});
      end
      fi.irq_done = 1'b1;
      step();
      fi.irq_done = 1'b0;
      step();
      tests++;
      if ({fi.irq_req, fi.irq_vec} !== 3'b1_00) begin
         fails++;
         $display("FAIL set_wins_rerequest: got %b expected 100", {fi.irq_req, fi.irq_vec});
      end
      fi.irq_ack = 1'b1;
      step();
      fi.irq_ack  = 1'b0;
      fi.irq_done = 1'b1;
      step();
      fi.irq_done = 1'b0;
      fi.irq_in   = '0;
      step();
   endtask

   task automatic test_handshake_abuse();
      do_reset();
      fi.irq_in = 4'b0100;
      step();
      fi.irq_ack = 1'b1;
      step();
      fi.irq_ack = 1'b0;
      tests++;
      if ({fi.irq_req, fi.busy, fi.pending} !== 6'b00_0100) begin
         fails++;
         $display("FAIL ack_in_idle: got %b expected 000100", {fi.irq_req, fi.busy, fi.pending});
      end
      fi.irq_mask = 4'hF;
      step();
      fi.irq_done = 1'b1;
      step();
      fi.irq_done = 1'b0;
      tests++;
      if ({fi.irq_req, fi.irq_vec, fi.busy} !== 4'b1_10_1) begin
         fails++;
         $display("FAIL done_in_req: got %b expected 1101", {fi.irq_req, fi.irq_vec, fi.busy});
      end
      fi.irq_ack  = 1'b1;
      fi.irq_done = 1'b1;
      step();
      fi.irq_ack  = 1'b0;
      fi.irq_done = 1'b0;
      tests++;
      if ({fi.irq_req, fi.busy, fi.pending} !== 6'b01_0000) begin
         fails++;
         $display("FAIL ack_done_same_cycle: got %b expected 010000",
                  {fi.irq_req, fi.busy, fi.pending});
      end
      step();
      tests++;
      if ({fi.busy, fi.irq_vec} !== 3'b1_10) begin
         fails++;
         $display("FAIL service_held: got %b expected 110", {fi.busy, fi.irq_vec});
      end
      fi.irq_done = 1'b1;
      step();
      fi.irq_done = 1'b0;
      tests++;
      if (fi.busy !== 1'b0) begin
         fails++;
         $display("FAIL done_in_service: got %b expected 0", fi.busy);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_masking();
      test_overrun();
      test_handshake_abuse();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
